dram_bank_ctrl: RTL

DRAM_BANK_CTRL -- requirements
Module: dram_bank_ctrl

---
 rtl/dram_bank_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/dram_bank_ctrl.sv
// Single-bank DRAM command sequencer with a one-entry request buffer and ACT/RD/WR/PRE/REF timing.
// Define BK_CLOSE_PAGE_EN for close-page policy (precharge after every RD/WR); default is open-page.
module dram_bank_ctrl #(
    parameter int ID_WIDTH = 4,
    parameter int RA_WIDTH = 15,
    parameter int CA_WIDTH = 10,
    parameter int TW       = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic [ID_WIDTH-1:0] req_id,
    input  logic [RA_WIDTH-1:0] req_ra,
    input  logic [CA_WIDTH-1:0] req_ca,
    input  logic [3:0]          req_len,
    input  logic                req_wr,
    output logic                req_ready,
    input  logic [TW-1:0]       t_rcd,
    input  logic [TW-1:0]       t_rp,
    input  logic [TW-1:0]       t_ras,
    input  logic [TW-1:0]       t_rfc,
    input  logic [TW-1:0]       t_rtp,
    input  logic [TW-1:0]       t_wtp,
    input  logic                ref_due,
    output logic                ref_ack,
    output logic                act_req,
    output logic                rd_req,
    output logic                wr_req,
    output logic                pre_req,
    output logic                ref_req,
    input  logic                act_gnt,
    input  logic                rd_gnt,
    input  logic                wr_gnt,
    input  logic                pre_gnt,
    input  logic                ref_gnt,
    output logic [RA_WIDTH-1:0] sched_ra,
    output logic [CA_WIDTH-1:0] sched_ca,
    output logic [ID_WIDTH-1:0] sched_id,
    output logic [3:0]          sched_len
);

    typedef enum logic [2:0] {IDLE, ACTIVATING, ACTIVE, PRECHARGING, REFRESHING} state_e;

    state_e                state_q, state_d;
    logic                  buf_vld_q, buf_vld_d;
    logic [ID_WIDTH-1:0]   buf_id_q, buf_id_d;
    logic [RA_WIDTH-1:0]   buf_ra_q, buf_ra_d;
    logic [CA_WIDTH-1:0]   buf_ca_q, buf_ca_d;
    logic [3:0]            buf_len_q, buf_len_d;
    logic                  buf_wr_q, buf_wr_d;
    logic [RA_WIDTH-1:0]   open_row_q, open_row_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic [TW-1:0]         ras_q, ras_d;
    logic [TW-1:0]         rtp_q, rtp_d;
    logic [TW-1:0]         wtp_q, wtp_d;
    logic                  row_hit, pre_ok, serve, need_pre;

    // Loading t-1 on a grant makes a counter hit 0 exactly t cycles later; t=0 behaves as t=1.
    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
        return (v == '0) ? '0 : v - TW'(1);
    endfunction

    assign row_hit = (buf_ra_q == open_row_q);
    assign pre_ok  = (ras_q == '0) && (rtp_q == '0) && (wtp_q == '0);

`ifdef BK_CLOSE_PAGE_EN
    logic done_q, done_d;
    assign serve    = buf_vld_q && row_hit && !done_q;
    assign need_pre = buf_vld_q || ref_due || done_q;
`else
    assign serve    = buf_vld_q && row_hit;
    assign need_pre = buf_vld_q || ref_due;
`endif

    // Outputs depend only on state, never on grants, so same-cycle grants form no loop.
    always_comb begin
        req_ready = !buf_vld_q && !ref_due;
        act_req   = 1'b0;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        pre_req   = 1'b0;
        ref_req   = 1'b0;
        sched_ra  = '0;
        sched_ca  = '0;
        sched_id  = '0;
        sched_len = '0;
        unique case (state_q)
            IDLE: begin
                if (buf_vld_q) begin
                    act_req  = 1'b1;
                    sched_ra = buf_ra_q;
                end else if (ref_due) begin
                    ref_req = 1'b1;
                end
            end
            ACTIVE: begin
                if (serve) begin
                    rd_req    = !buf_wr_q;
                    wr_req    = buf_wr_q;
                    sched_ra  = buf_ra_q;
                    sched_ca  = buf_ca_q;
                    sched_id  = buf_id_q;
                    sched_len = buf_len_q;
                end else if (need_pre && pre_ok) begin
                    pre_req  = 1'b1;
                    sched_ra = open_row_q;
                end
            end
            default: ;
        endcase
    end

    assign ref_ack = ref_req && ref_gnt;

    always_comb begin
        state_d    = state_q;
        buf_vld_d  = buf_vld_q;
        buf_id_d   = buf_id_q;
        buf_ra_d   = buf_ra_q;
        buf_ca_d   = buf_ca_q;
        buf_len_d  = buf_len_q;
        buf_wr_d   = buf_wr_q;
        open_row_d = open_row_q;
        tmr_d      = dec_sat(tmr_q);
        ras_d      = dec_sat(ras_q);
        rtp_d      = dec_sat(rtp_q);
        wtp_d      = dec_sat(wtp_q);
`ifdef BK_CLOSE_PAGE_EN
        done_d     = done_q;
`endif
        if (req_valid && req_ready) begin
            buf_vld_d = 1'b1;
            buf_id_d  = req_id;
            buf_ra_d  = req_ra;
            buf_ca_d  = req_ca;
            buf_len_d = req_len;
            buf_wr_d  = req_wr;
        end
        unique case (state_q)
            IDLE: begin
                if (act_req && act_gnt) begin
                    open_row_d = buf_ra_q;
                    ras_d      = dec_sat(t_ras);
                    tmr_d      = dec_sat(t_rcd);
                    state_d    = (dec_sat(t_rcd) == '0) ? ACTIVE : ACTIVATING;
`ifdef BK_CLOSE_PAGE_EN
                    done_d     = 1'b0;
`endif
                end else if (ref_req && ref_gnt) begin
                    tmr_d   = dec_sat(t_rfc);
                    state_d = (dec_sat(t_rfc) == '0) ? IDLE : REFRESHING;
                end
            end
            ACTIVATING: begin
                if (tmr_q <= TW'(1)) state_d = ACTIVE;
            end
            ACTIVE: begin
                if ((rd_req && rd_gnt) || (wr_req && wr_gnt)) begin
                    buf_vld_d = 1'b0;
                    if (rd_req) rtp_d = dec_sat(t_rtp);
                    else        wtp_d = dec_sat(t_wtp);
`ifdef BK_CLOSE_PAGE_EN
                    done_d    = 1'b1;
`endif
                end else if (pre_req && pre_gnt) begin
                    tmr_d   = dec_sat(t_rp);
                    state_d = (dec_sat(t_rp) == '0) ? IDLE : PRECHARGING;
                end
            end
            PRECHARGING, REFRESHING: begin
                if (tmr_q <= TW'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            buf_vld_q  <= 1'b0;
            buf_id_q   <= '0;
            buf_ra_q   <= '0;
            buf_ca_q   <= '0;
            buf_len_q  <= '0;
            buf_wr_q   <= 1'b0;
            open_row_q <= '0;
            tmr_q      <= '0;
            ras_q      <= '0;
            rtp_q      <= '0;
            wtp_q      <= '0;
`ifdef BK_CLOSE_PAGE_EN
            done_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            buf_vld_q  <= buf_vld_d;
            buf_id_q   <= buf_id_d;
            buf_ra_q   <= buf_ra_d;
            buf_ca_q   <= buf_ca_d;
            buf_len_q  <= buf_len_d;
            buf_wr_q   <= buf_wr_d;
            open_row_q <= open_row_d;
            tmr_q      <= tmr_d;
            ras_q      <= ras_d;
            rtp_q      <= rtp_d;
            wtp_q      <= wtp_d;
`ifdef BK_CLOSE_PAGE_EN
            done_q     <= done_d;
`endif
        end
    end

endmodule
